// File: rtl/uart_tx.sv
// uart_tx: UART transmitter sending a start bit, DATA_BITS data bits LSB first, an optional even parity bit and the stop bit(s).
// Define UART_TX_TWO_STOP_EN for two stop bits; otherwise one stop bit is sent.
module uart_tx #(
   parameter int BAUD_DIV      = 434,
   parameter int DATA_BITS     = 8,
   parameter int ENABLE_PARITY = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 valid,
   output logic                 ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);
`ifdef UART_TX_TWO_STOP_EN
   localparam int STOP_BITS = 2;
`else
   localparam int STOP_BITS = 1;
`endif
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t               state_q;
   logic [15:0]          baud_q;
   logic [3:0]           bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_q, tx_q, tx_d, ready_q, busy_q, done_q, bit_end;
   assign bit_end = baud_q == 16'(BAUD_DIV - 1);
   // The line is the state's level delayed by one register, so tx falls on the edge after accept.
   always_comb tx_d = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : state_q == PARITY ? par_q : 1'b1;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         tx_q   <= tx_d;
         baud_q <= (state_q == IDLE || bit_end) ? '0 : baud_q + 16'd1;
         case (state_q)
            IDLE: if (valid && ready_q) begin
               shift_q <= data_in;
               par_q   <= ^data_in;
               state_q <= START;
               ready_q <= 1'b0;
               busy_q  <= 1'b1;
            end
            START: if (bit_end) state_q <= DATA;
            DATA: if (bit_end) begin
               shift_q <= shift_q >> 1;
               bit_q   <= bit_q == 4'(DATA_BITS - 1) ? '0 : bit_q + 4'd1;
               if (bit_q == 4'(DATA_BITS - 1)) state_q <= ENABLE_PARITY != 0 ? PARITY : STOP;
            end
            PARITY: if (bit_end) state_q <= STOP;
            STOP: if (bit_end) begin
               bit_q <= bit_q == 4'(STOP_BITS - 1) ? '0 : bit_q + 4'd1;
               if (bit_q == 4'(STOP_BITS - 1)) begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign tx    = tx_q;
   assign ready = ready_q;
   assign busy  = busy_q;
   assign done  = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx; three instances cover parity on/off and BAUD_DIV=1.
// A line monitor decodes each frame cycle by cycle and compares it against queued expected frames.
module tb_uart_tx;
`ifdef UART_TX_TWO_STOP_EN
   localparam int STOPB = 2;
`else
   localparam int STOPB = 1;
`endif
   localparam int BD [3] = '{4, 4, 1};
   localparam int PAR [3] = '{1, 0, 1};
   typedef struct {
      logic [15:0] bits;
      int          nb;
      int          gap;
   } fr_t;
   logic       clk = 1'b0;
   logic [7:0] din [3];
   logic       vld [3], rst_v [3], rdy [3], txl [3], bsy [3], dn [3], acc [3];
   fr_t        q [3][$];
   fr_t        cur [3];
   logic [15:0] rec [3];
   bit         inf [3], bad [3], pend [3];
   int         tc [3], gapc [3];
   int         n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   uart_tx #(.BAUD_DIV(4), .DATA_BITS(8), .ENABLE_PARITY(1)) u0 (
      .clk(clk), .rst(rst_v[0]), .data_in(din[0]), .valid(vld[0]),
      .ready(rdy[0]), .tx(txl[0]), .busy(bsy[0]), .done(dn[0]));
   uart_tx #(.BAUD_DIV(4), .DATA_BITS(8), .ENABLE_PARITY(0)) u1 (
      .clk(clk), .rst(rst_v[1]), .data_in(din[1]), .valid(vld[1]),
      .ready(rdy[1]), .tx(txl[1]), .busy(bsy[1]), .done(dn[1]));
   uart_tx #(.BAUD_DIV(1), .DATA_BITS(8), .ENABLE_PARITY(1)) u2 (
      .clk(clk), .rst(rst_v[2]), .data_in(din[2]), .valid(vld[2]),
      .ready(rdy[2]), .tx(txl[2]), .busy(bsy[2]), .done(dn[2]));
   always @(posedge clk) for (int i = 0; i < 3; i++) acc[i] <= vld[i] && rdy[i] && !rst_v[i];
   function automatic fr_t build(int i, logic [7:0] d, int gap);
      fr_t f;
      f.bits = '1;
      f.bits[0] = 1'b0;
      f.bits[8:1] = d;
      if (PAR[i] != 0) f.bits[9] = ^d;
      f.nb = 1 + 8 + PAR[i] + STOPB;
      f.gap = gap;
      return f;
   endfunction
   task automatic chk(string nm, int i, logic [15:0] act, logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[u%0d] at %0t: got %0h, expected %0h", nm, i, $time, act, exp);
      end
   endtask
   task automatic mon(int i);
      int last;
      if (rst_v[i]) begin
         chk("reset_state", i, 16'({txl[i], rdy[i], bsy[i], dn[i]}), 16'b1100);
         inf[i] = 0;
         pend[i] = 0;
         gapc[i] = 0;
         return;
      end
      if (pend[i]) begin
         chk("latency_tx_low", i, 16'(txl[i]), 16'd0);
         pend[i] = 0;
      end
      if (acc[i]) begin
         chk("tx_high_at_accept", i, 16'(txl[i]), 16'd1);
         pend[i] = 1;
      end
      if (!inf[i]) begin
         chk("idle_no_done", i, 16'(dn[i]), 16'd0);
         if (!txl[i]) begin
            if (q[i].size() == 0) chk("unexpected_start", i, 16'd1, 16'd0);
            else begin
               cur[i] = q[i].pop_front();
               if (cur[i].gap >= 0) chk("gap", i, 16'(gapc[i]), 16'(cur[i].gap));
               inf[i] = 1;
               tc[i] = 0;
               rec[i] = '1;
               bad[i] = 0;
            end
         end else gapc[i]++;
      end
      if (inf[i]) begin
         last = cur[i].nb * BD[i] - 1;
         if (tc[i] % BD[i] == 0) rec[i][tc[i] / BD[i]] = txl[i];
         else if (txl[i] !== rec[i][tc[i] / BD[i]]) bad[i] = 1;
         if (tc[i] < last && {dn[i], rdy[i], bsy[i]} !== 3'b001) bad[i] = 1;
         if (tc[i] == last) begin
            chk("done_ready_busy", i, 16'({dn[i], rdy[i], bsy[i]}), 16'b110);
            chk("frame", i, rec[i], cur[i].bits);
            chk("bit_hold_and_flags", i, 16'(bad[i]), 16'd0);
            inf[i] = 0;
            gapc[i] = 0;
         end else tc[i]++;
      end
   endtask
   initial forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) mon(i);
   end
   task automatic send(int i, logic [7:0] d, bit keep, int gap);
      int n = 0;
      din[i] = d;
      vld[i] = 1'b1;
      while (!rdy[i]) begin
         @(negedge clk);
         n++;
         if (n > 3000) begin
            $display("FAIL send_timeout[u%0d]: got ready=0, expected ready=1 within 3000 cycles", i);
            $fatal(1);
         end
      end
      q[i].push_back(build(i, d, gap));
      @(negedge clk);
      if (!keep) vld[i] = 1'b0;
   endtask
   task automatic wait_idle(int i);
      int n = 0;
      while (q[i].size() != 0 || inf[i]) begin
         @(negedge clk);
         n++;
         if (n > 3000) begin
            $display("FAIL idle_timeout[u%0d]: got frame pending, expected idle within 3000 cycles", i);
            $fatal(1);
         end
      end
      repeat (3) @(negedge clk);
   endtask
   initial begin
      for (int i = 0; i < 3; i++) begin
         din[i] = '0;
         vld[i] = 1'b0;
         rst_v[i] = 1'b1;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
      repeat (2) @(negedge clk);
      send(0, 8'hA5, 0, -1);
      wait_idle(0);
      send(1, 8'h00, 1, -1);
      send(1, 8'hFF, 0, 1);
      wait_idle(1);
      send(0, 8'h3C, 0, -1);
      repeat (10) @(negedge clk);
      din[0] = 8'hFF;
      wait_idle(0);
      send(0, 8'h0F, 0, -1);
      repeat (6) @(negedge clk);
      din[0] = 8'h55;
      vld[0] = 1'b1;
      repeat (10) @(negedge clk);
      vld[0] = 1'b0;
      wait_idle(0);
      repeat (5) @(negedge clk);
      send(0, 8'h55, 0, -1);
      wait_idle(0);
      send(0, 8'hA5, 0, -1);
      repeat (14) @(negedge clk);
      rst_v[0] = 1'b1;
      @(negedge clk);
      rst_v[0] = 1'b0;
      q[0].delete();
      repeat (6) @(negedge clk);
      send(0, 8'h81, 0, -1);
      wait_idle(0);
      send(2, 8'hA5, 1, -1);
      send(2, 8'h3C, 0, 1);
      wait_idle(2);
      repeat (10) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
